mult16_seq_ctrl: RTL and testbench

//   Sequencer that builds a 16x16 unsigned multiply from one shared 8x8 unsigned

---
 rtl/mult16_seq_ctrl.sv | 104 ++++++++++
 tb/tb_mult16_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult16_seq_ctrl.sv
// 16x16 unsigned multiply sequenced over four cycles through one shared 8x8 multiplier.
// Byte partial products are shifted into a 32-bit accumulator; start/done handshake.

module multiplier8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] result
);
    assign result = a * b;
endmodule

module mult16_seq_ctrl #(
    parameter bit HOLD_RESULT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state, state_next;
    logic [1:0]  step;
    logic [15:0] a_q, b_q;
    logic [31:0] acc, pp_shifted, acc_sum;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] pp;
    logic        accept;

    multiplier8 u_mul (.a(mul_a), .b(mul_b), .result(pp));

    assign busy    = (state == MUL);
    assign ready   = ~busy;
    assign done    = (state == DONE);
    assign accept  = start && ready;
    assign acc_sum = acc + pp_shifted;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MUL;
            MUL: begin
                if (abort)            state_next = IDLE;
                else if (step == 2'd3) state_next = DONE;
            end
            DONE:    state_next = start ? MUL : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Byte select and shift per step; multiplier inputs stay at zero outside MUL.
    always_comb begin
        mul_a      = 8'd0;
        mul_b      = 8'd0;
        pp_shifted = 32'd0;
        if (state == MUL) begin
            case (step)
                2'd0: begin mul_a = a_q[7:0];  mul_b = b_q[7:0];  pp_shifted = {16'd0, pp};       end
                2'd1: begin mul_a = a_q[7:0];  mul_b = b_q[15:8]; pp_shifted = {8'd0, pp, 8'd0};  end
                2'd2: begin mul_a = a_q[15:8]; mul_b = b_q[7:0];  pp_shifted = {8'd0, pp, 8'd0};  end
                default: begin mul_a = a_q[15:8]; mul_b = b_q[15:8]; pp_shifted = {pp, 16'd0};   end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            step    <= 2'd0;
            acc     <= 32'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            product <= 32'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_q  <= op_a;
                b_q  <= op_b;
                acc  <= 32'd0;
                step <= 2'd0;
            end else if (state == MUL) begin
                if (abort) begin
                    step <= 2'd0;
                end else begin
                    acc  <= acc_sum;
                    step <= step + 2'd1;
                end
            end

            if (state == MUL && !abort && step == 2'd3)
                product <= acc_sum;
            else if (!HOLD_RESULT && state == DONE)
                product <= 32'd0;
        end
    end
endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Self-checking bench: two instances (hold and clear variants) share stimulus and are
// compared against a plain-arithmetic product model with randomized operands.

module tb_mult16_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] op_a, op_b;
    logic        ready1, busy1, done1, ready0, busy0, done0;
    logic [31:0] product1, product0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] held;

    always #5 clk = ~clk;

    mult16_seq_ctrl #(.HOLD_RESULT(1'b1)) dut_hold (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .op_a(op_a), .op_b(op_b),
        .ready(ready1), .busy(busy1), .done(done1), .product(product1)
    );

    mult16_seq_ctrl #(.HOLD_RESULT(1'b0)) dut_clear (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .op_a(op_a), .op_b(op_b),
        .ready(ready0), .busy(busy0), .done(done0), .product(product0)
    );

    function automatic logic [31:0] ref_product(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] wa, wb;
        wa = {16'd0, a};
        wb = {16'd0, b};
        return wa * wb;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ab);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        abort = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Counts edges from the accept edge until done shows; optional start noise while busy.
    task automatic wait_done(input bit noise, output int n);
        n = 0;
        while (!(done1 && done0) && n < 12) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                op_a  = 16'($urandom);
                op_b  = 16'($urandom);
            end
            tick();
            n++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; op_a = 16'd0; op_b = 16'd0;
        repeat (2) tick();
        checks++;
        if ({ready1, busy1, done1, ready0, busy0, done0} !== 6'b100100 || product1 !== 32'd0 || product0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state flags=%b product1=%h product0=%h want flags=100100 product=0",
                     {ready1, busy1, done1, ready0, busy0, done0}, product1, product0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({ready1, busy1, done1} !== 3'b100 || product1 !== 32'd0) begin
            errors++;
            $display("FAIL after_release flags=%b product=%h want 100 / 0", {ready1, busy1, done1}, product1);
        end
        held = 32'd0;
    endtask

    task automatic test_directed();
        logic [15:0] av [4] = '{16'h0001, 16'hFFFF, 16'h1234, 16'h0081};
        logic [15:0] bv [4] = '{16'h0001, 16'hFFFF, 16'h5678, 16'h0081};
        logic [31:0] sv [4] = '{32'h00000001, 32'hFFFE0001, 32'h06260060, 32'h00004101};
        int n;
        for (int i = 0; i < 4; i++) begin
            issue(av[i], bv[i], 1'b0);
            checks++;
            if ({ready1, busy1, done1} !== 3'b010) begin
                errors++;
                $display("FAIL dir_busy[%0d] flags=%b want 010", i, {ready1, busy1, done1});
            end
            wait_done(1'b0, n);
            checks++;
            if (n !== 4) begin
                errors++;
                $display("FAIL dir_latency[%0d] edges=%0d want 4", i, n);
            end
            checks++;
            if (product1 !== sv[i] || product0 !== sv[i] || product1 !== ref_product(av[i], bv[i])) begin
                errors++;
                $display("FAIL dir_product[%0d] got %h/%h want %h", i, product1, product0, sv[i]);
            end
            held = sv[i];
            tick();
            checks++;
            if (done1 !== 1'b0 || done0 !== 1'b0 || product1 !== held || product0 !== 32'd0) begin
                errors++;
                $display("FAIL dir_after_done[%0d] done=%b%b product1=%h product0=%h want 00 %h 0",
                         i, done1, done0, product1, product0, held);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(16'h1234, 16'h0002, 1'b0);
        wait_done(1'b1, n);
        checks++;
        if (n !== 4 || product1 !== ref_product(16'h1234, 16'h0002)) begin
            errors++;
            $display("FAIL b2b_first edges=%0d product=%h want 4 %h", n, product1, ref_product(16'h1234, 16'h0002));
        end
        held = product1 === ref_product(16'h1234, 16'h0002) ? product1 : ref_product(16'h1234, 16'h0002);
        issue(16'h00FF, 16'h0100, 1'b0);
        checks++;
        if (busy1 !== 1'b1 || product1 !== held || product0 !== 32'd0) begin
            errors++;
            $display("FAIL b2b_accept busy=%b product1=%h product0=%h want 1 %h 0", busy1, product1, product0, held);
        end
        wait_done(1'b1, n);
        checks++;
        if (n !== 4 || product1 !== 32'h0000FF00 || product0 !== 32'h0000FF00) begin
            errors++;
            $display("FAIL b2b_second edges=%0d product=%h/%h want 4 0000ff00", n, product1, product0);
        end
        held = 32'h0000FF00;
        tick();
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic [31:0] exp;
        int n;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0:       begin a = 16'hFFFF; b = 16'($urandom); end
                1:       begin a = 16'($urandom); b = 16'h0000; end
                default: begin a = 16'($urandom); b = 16'($urandom); end
            endcase
            exp = ref_product(a, b);
            repeat ($urandom_range(0, 2)) tick();
            issue(a, b, 1'b0);
            wait_done(1'($urandom_range(0, 1)), n);
            checks++;
            if (n !== 4 || product1 !== exp || product0 !== exp) begin
                errors++;
                $display("FAIL rand[%0d] %h*%h edges=%0d product=%h/%h want 4 %h", i, a, b, n, product1, product0, exp);
            end
            held = exp;
            tick();
            checks++;
            if (product1 !== held || product0 !== 32'd0 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL rand_hold[%0d] product=%h/%h done=%b want %h/0 0", i, product1, product0, done1, held);
            end
        end
    endtask

    task automatic test_abort();
        bit seen;
        int n;
        issue(16'h1234, 16'h5678, 1'b0);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({ready1, busy1, done1, done0} !== 4'b1000 || product1 !== held || product0 !== 32'd0) begin
            errors++;
            $display("FAIL abort_idle flags=%b product=%h/%h want 1000 %h/0", {ready1, busy1, done1, done0}, product1, product0, held);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done1 || done0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || product1 !== held) begin
            errors++;
            $display("FAIL abort_no_done seen=%b product=%h want 0 %h", seen, product1, held);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({ready1, busy1} !== 2'b10 || product1 !== held) begin
            errors++;
            $display("FAIL abort_in_idle flags=%b product=%h want 10 %h", {ready1, busy1}, product1, held);
        end
        issue(16'h0003, 16'h0005, 1'b1);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL start_beats_abort busy=%b want 1", busy1);
        end
        wait_done(1'b0, n);
        checks++;
        if (n !== 4 || product1 !== 32'd15) begin
            errors++;
            $display("FAIL start_abort_result edges=%0d product=%h want 4 0000000f", n, product1);
        end
        held = 32'd15;
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        int n;
        issue(16'hABCD, 16'h1111, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (product1 !== 32'd0 || product0 !== 32'd0 || {ready1, busy1, done1} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid product=%h/%h flags=%b want 0 100", product1, product0, {ready1, busy1, done1});
        end
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done1 || done0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || product1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_quiet seen=%b product=%h want 0 0", seen, product1);
        end
        issue(16'h00FF, 16'h00FF, 1'b0);
        wait_done(1'b0, n);
        checks++;
        if (n !== 4 || product1 !== ref_product(16'h00FF, 16'h00FF)) begin
            errors++;
            $display("FAIL reset_recover edges=%0d product=%h want 4 %h", n, product1, ref_product(16'h00FF, 16'h00FF));
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
